// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode/funct constants, ALU op enum and ALU function shared by the datapath
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT} alu_op_t;
  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    return op == ALU_SUB ? a - b :
           op == ALU_AND ? a & b :
           op == ALU_OR  ? a | b :
           op == ALU_XOR ? a ^ b :
           op == ALU_SLT ? {31'd0, $signed(a) < $signed(b)} : a + b;
  endfunction
endpackage

// File: rtl/regfile.sv
// regfile: 32x32 register file, two combinational read ports, one write port, x0 hardwired to zero
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [32];
  always_ff @(posedge clk)
    if (rst) regs <= '{default: '0};
    else if (we && wa != 5'd0) regs[wa] <= wd;
  assign rd1 = ra1 == 5'd0 ? '0 : regs[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : regs[ra2];
endmodule

// File: rtl/riscv_datapath.sv
// riscv_datapath: single-cycle RV32I subset core; decode, immediates, ALU, data memory and PC
module riscv_datapath
  import riscv_pkg::*;
#(
  parameter int DMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  output logic [31:0] data_out,
  output logic [31:0] pc
);
  localparam int AW = $clog2(DMEM_BYTES);
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [31:0] imm_i, imm_s, imm_b, rs1v, rs2v, alu_res, ld_val, ld_word;
  logic [7:0] ld_byte;
  logic [AW-1:0] ea;
  logic [AW-3:0] wa;
  alu_op_t alu_op;
  logic alu_ok, ld, st, br, taken;
  logic [7:0] mem [DMEM_BYTES] = '{default: '0};
  assign opcode = instruction[6:0];
  assign f3 = instruction[14:12];
  assign f7 = instruction[31:25];
  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
  always_comb begin
    alu_op = ALU_ADD;
    alu_ok = 1'b0;
    ld = 1'b0;
    st = 1'b0;
    br = 1'b0;
    case (opcode)
      OP_R: begin
        alu_ok = (f7 == F7_BASE && f3 inside {F3_ADD, F3_SLT, F3_XOR, F3_OR, F3_AND}) || (f7 == F7_SUB && f3 == F3_ADD);
        alu_op = f7 == F7_SUB ? ALU_SUB : f3 == F3_SLT ? ALU_SLT : f3 == F3_XOR ? ALU_XOR :
                 f3 == F3_OR ? ALU_OR : f3 == F3_AND ? ALU_AND : ALU_ADD;
      end
      OP_IMM:    alu_ok = f3 == F3_ADD;
      OP_LOAD:   ld = f3 inside {F3_LB, F3_LW, F3_LBU};
      OP_STORE:  st = f3 inside {F3_SB, F3_SW};
      OP_BRANCH: br = f3 inside {F3_BEQ, F3_BNE};
      default: ;
    endcase
  end
  regfile u_rf (
    .clk(clk), .rst(reset), .we(!reset && (alu_ok || ld)),
    .ra1(instruction[19:15]), .ra2(instruction[24:20]), .wa(instruction[11:7]),
    .wd(alu_ok ? alu_res : ld_val), .rd1(rs1v), .rd2(rs2v)
  );
  assign alu_res = alu(alu_op, rs1v, opcode == OP_R ? rs2v : imm_i);
  assign ea = AW'(rs1v + (st ? imm_s : imm_i));
  assign wa = ea[AW-1:2];
  assign ld_byte = mem[ea];
  assign ld_word = {mem[{wa, 2'd3}], mem[{wa, 2'd2}], mem[{wa, 2'd1}], mem[{wa, 2'd0}]};
  assign ld_val = f3 == F3_LW ? ld_word : f3 == F3_LBU ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
  assign taken = br && ((rs1v == rs2v) ^ (f3 == F3_BNE));
  assign data_out = reset ? '0 : alu_ok ? alu_res : ld ? ld_val : st ? rs2v : '0;
  // memory is deliberately not cleared by reset, only gated by it
  always_ff @(posedge clk)
    if (!reset && st)
      if (f3 == F3_SW)
        for (int i = 0; i < 4; i++) mem[{wa, 2'(i)}] <= rs2v[8*i +: 8];
      else mem[ea] <= rs2v[7:0];
  always_ff @(posedge clk)
    if (reset) pc <= '0;
    else pc <= taken ? pc + imm_b : pc + 32'd4;
endmodule

// File: tb/tb_riscv_datapath.sv
// tb_riscv_datapath: directed instruction sequence with hand-computed data_out and pc
module tb_riscv_datapath;
  logic clk, reset;
  logic [31:0] instruction, data_out, pc;
  int checks = 0;
  int errors = 0;
  riscv_datapath #(.DMEM_BYTES(1024)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .data_out(data_out), .pc(pc)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic exec(input string tag, input logic [31:0] ins, input logic [31:0] exp_do, input logic [31:0] exp_pc);
    instruction = ins;
    #2;
    check({tag, " data_out"}, data_out, exp_do);
    @(posedge clk);
    #1;
    check({tag, " pc"}, pc, exp_pc);
  endtask
  initial begin
    reset = 1'b1;
    instruction = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset pc", pc, 32'h0);
    check("reset data_out", data_out, 32'h0);
    instruction = 32'h00500093;
    #2;
    check("reset masks addi", data_out, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exec("nop1", 32'h00000000, 32'h0, 32'd4);
    exec("nop2", 32'h00000000, 32'h0, 32'd8);
    exec("nop3", 32'h00000000, 32'h0, 32'd12);
    exec("addi x1", 32'h00500093, 32'd5, 32'd16);
    exec("beq taken", 32'h00000863, 32'h0, 32'd32);
    exec("bne not taken", 32'h00001863, 32'h0, 32'd36);
    exec("add x2", 32'h00108133, 32'd10, 32'd40);
    exec("sub x3", 32'h401001B3, 32'hFFFFFFFB, 32'd44);
    exec("slt x4", 32'h0011A233, 32'd1, 32'd48);
    exec("slt signed", 32'h0030A4B3, 32'd0, 32'd52);
    exec("and", 32'h0030F533, 32'd1, 32'd56);
    exec("or", 32'h0030E5B3, 32'hFFFFFFFF, 32'd60);
    exec("xor", 32'h0030C633, 32'hFFFFFFFE, 32'd64);
    exec("addi x5", 32'h08000293, 32'h80, 32'd68);
    exec("sb", 32'h005001A3, 32'h80, 32'd72);
    exec("lb", 32'h00300303, 32'hFFFFFF80, 32'd76);
    exec("lbu", 32'h00304303, 32'h80, 32'd80);
    exec("sw", 32'h00302423, 32'hFFFFFFFB, 32'd84);
    exec("lw after sw", 32'h00802383, 32'hFFFFFFFB, 32'd88);
    exec("lw unaligned", 32'h00B02383, 32'hFFFFFFFB, 32'd92);
    exec("lbu little endian", 32'h00804303, 32'hFB, 32'd96);
    exec("use loaded x7", 32'h000386B3, 32'hFFFFFFFB, 32'd100);
    exec("addi x0", 32'h00700013, 32'd7, 32'd104);
    exec("add x8 x0", 32'h00000433, 32'd0, 32'd108);
    exec("mul is nop", 32'h02108733, 32'd0, 32'd112);
    exec("x14 untouched", 32'h000707B3, 32'd0, 32'd116);
    exec("beq back", 32'hFE000CE3, 32'h0, 32'd108);
    exec("bne taken", 32'h00009463, 32'h0, 32'd116);
    exec("beq not taken", 32'h00008463, 32'h0, 32'd120);
    reset = 1'b1;
    instruction = 32'h00102423;
    #2;
    check("midrun reset data_out", data_out, 32'h0);
    @(posedge clk);
    #1;
    check("midrun reset pc", pc, 32'h0);
    reset = 1'b0;
    exec("mem kept after reset", 32'h00802383, 32'hFFFFFFFB, 32'd4);
    exec("x1 cleared", 32'h000086B3, 32'd0, 32'd8);
    exec("byte kept", 32'h00304303, 32'h80, 32'd12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
